instr_fetch_unit: RTL

Instruction fetch front end for the multi-cycle RISC-V core. It owns the fetch PC, drives word addresses into the combinational instruction memory and captures the returned words into a small prefetch queue. The queue feeds decode through a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at a new target.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, combinational imem interface and a prefetch queue to decode.
// Optional misaligned-redirect trap is compiled in with `define IFETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    logic [31:0]   fpc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   target;
    logic          fault;
    logic          push;
    logic          pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign target = redirect_pc;

    // A misaligned redirect parks fetch until the next aligned redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault <= 1'b0;
        end else if (redirect) begin
            fault <= |redirect_pc[1:0];
        end
    end
`else
    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign fault  = 1'b0;
`endif

    assign imem_addr   = fpc;
    assign instr_valid = (count != '0);
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign fetch_fault = fault;

    assign pop  = instr_valid & instr_ready & ~redirect;
    assign push = fetch_en & ~redirect & ~fault & ((count < QFULL) | pop);

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpc    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect) begin
            fpc    <= target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= imem_rd;
                q_pc[wr_ptr]    <= fpc;
                wr_ptr          <= wr_ptr + PW'(1);
                fpc             <= fpc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
